alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_issue_stage_if.sv | 47 ++++
 rtl/alu_issue_stage.sv | 126 ++++++++++++
 tb/tb_alu_issue_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage and its testbench.
// Flag indices give the bit position of each ALU flag inside out_flags.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SRL = 4'd6,
    OP_SLL = 4'd7,
    OP_SRA = 4'd8,
    OP_SLA = 4'd9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } stage_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue stage's handshake and ALU-side signals.
// The master side is upstream, consumer and ALU; the slave side is the stage.
interface alu_issue_stage_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [3:0]       in_sel;

  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [3:0]       alu_sel;
  logic [N-1:0]     alu_result;
  logic             alu_neg;
  logic             alu_zero;
  logic             alu_cout;
  logic             alu_ovf;

  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_result;
  logic [3:0]       out_flags;
  logic [3:0]       out_sel;
  logic             out_err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_a, in_b, in_sel,
    output alu_result, alu_neg, alu_zero, alu_cout, alu_ovf,
    output out_ready,
    input  in_ready, alu_a, alu_b, alu_sel,
    input  out_valid, out_result, out_flags, out_sel, out_err, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel,
    input  alu_result, alu_neg, alu_zero, alu_cout, alu_ovf,
    input  out_ready,
    output in_ready, alu_a, alu_b, alu_sel,
    output out_valid, out_result, out_flags, out_sel, out_err, op_count
  );

endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage around an external combinational ALU: registers one operation,
// captures the ALU response a cycle later and offers it to the consumer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_state_e     state_q, state_d;
  logic [N-1:0]     alu_a_q, alu_a_d;
  logic [N-1:0]     alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [N-1:0]     out_result_q, out_result_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic [3:0]       out_sel_q, out_sel_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             in_ready_s;

  // Next-state, operand latch, result capture and handshake decode.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_sel_d    = out_sel_q;
    out_err_d    = out_err_q;
    op_count_d   = op_count_q;
    in_ready_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          alu_a_d   = bus.in_a;
          alu_b_d   = bus.in_b;
          alu_sel_d = bus.in_sel;
          state_d   = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        out_result_d         = bus.alu_result;
        out_flags_d[FLAG_N]  = bus.alu_neg;
        out_flags_d[FLAG_Z]  = bus.alu_zero;
        out_flags_d[FLAG_C]  = bus.alu_cout;
        out_flags_d[FLAG_V]  = bus.alu_ovf;
        out_sel_d            = alu_sel_q;
        out_err_d            = (alu_sel_q > ALU_OP_MAX);
        state_d              = ST_DONE;
      end
      ST_DONE: begin
        // Releasing the result frees the operand registers in the same cycle.
        in_ready_s = bus.out_ready;
        if (bus.out_ready) begin
          op_count_d = op_count_q + CNT_ONE;
          if (bus.in_valid) begin
            alu_a_d   = bus.in_a;
            alu_b_d   = bus.in_b;
            alu_sel_d = bus.in_sel;
            state_d   = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= {N{1'b0}};
      alu_b_q      <= {N{1'b0}};
      alu_sel_q    <= 4'd0;
      out_result_q <= {N{1'b0}};
      out_flags_q  <= 4'd0;
      out_sel_q    <= 4'd0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      op_count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_sel_q    <= out_sel_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;
  assign bus.out_sel    = out_sel_q;
  assign bus.out_err    = out_err_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: acts as upstream, consumer and the ALU itself,
// checking directed scenarios and a randomized run against a transaction queue.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_count = 0;
  int   edges = 0;
  logic [N+3:0] alu_m;

  alu_issue_stage_if #(.N(N), .CNT_W(CNT_W)) ifc ();

  alu_issue_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Behavioural ALU: returns {result, neg, zero, cout, ovf}.
  function automatic logic [N+3:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] sel);
    logic [N:0]   w;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (sel)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[N-1:0]; c = w[N]; v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
      4'd1: begin w = {1'b0, a} + {1'b0, ~b} + 9'd1; r = w[N-1:0]; c = w[N]; v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
      4'd2: r = ~a;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: begin r = a >> 1; c = a[0]; end
      4'd7: begin r = a << 1; c = a[N-1]; end
      4'd8: begin r = N'($signed(a) >>> 1); c = a[0]; end
      4'd9: begin r = a << 1; c = a[N-1]; v = a[N-1] ^ a[N-2]; end
      default: r = '0;
    endcase
    return {r, r[N-1], (r == '0), c, v};
  endfunction

  always_comb begin
    alu_m = alu_model(ifc.alu_a, ifc.alu_b, ifc.alu_sel);
    ifc.alu_result = alu_m[N+3:4];
    ifc.alu_neg    = alu_m[3];
    ifc.alu_zero   = alu_m[2];
    ifc.alu_cout   = alu_m[1];
    ifc.alu_ovf    = alu_m[0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_count = 0;
  endtask

  // Drive one output handshake from DONE with no new input.
  task automatic consume();
    ifc.out_ready = 1'b1; ifc.in_valid = 1'b0;
    tick();
    ifc.out_ready = 1'b0;
    exp_count++;
  endtask

  // Present an operation for exactly one edge; caller knows in_ready is high.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] sel);
    ifc.in_a = a; ifc.in_b = b; ifc.in_sel = sel; ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_sel = 4'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    checks++; if (ifc.out_result !== 8'h00) begin errors++; $display("FAIL reset_out_result: got %h want 00", ifc.out_result); end
    checks++; if (ifc.op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d want 0", ifc.op_count); end
    checks++; if ({ifc.alu_a, ifc.alu_b, ifc.alu_sel} !== 20'd0) begin errors++; $display("FAIL reset_alu_regs: got %h want 0", {ifc.alu_a, ifc.alu_b, ifc.alu_sel}); end
    checks++; if ({ifc.out_flags, ifc.out_sel, ifc.out_err} !== 9'd0) begin errors++; $display("FAIL reset_out_regs: got %h want 0", {ifc.out_flags, ifc.out_sel, ifc.out_err}); end
    exp_count = 0;
  endtask

  task automatic test_add();
    logic [N+3:0] m;
    m = alu_model(8'h7F, 8'h01, 4'd0);
    ifc.in_a = 8'h7F; ifc.in_b = 8'h01; ifc.in_sel = 4'd0; ifc.in_valid = 1'b1;
    #1;
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready_idle: got %b want 1", ifc.in_ready); end
    tick();
    ifc.in_valid = 1'b0;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid: got %b want 0", ifc.out_valid); end
    checks++; if (ifc.in_ready !== 1'b0) begin errors++; $display("FAIL add_exec_ready: got %b want 0", ifc.in_ready); end
    checks++; if ({ifc.alu_a, ifc.alu_b, ifc.alu_sel} !== {8'h7F, 8'h01, 4'd0}) begin errors++; $display("FAIL add_alu_regs: got %h want 7f010", {ifc.alu_a, ifc.alu_b, ifc.alu_sel}); end
    tick();
    checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL add_done_valid: got %b want 1", ifc.out_valid); end
    checks++; if (ifc.out_result !== 8'h80) begin errors++; $display("FAIL add_result: got %h want 80", ifc.out_result); end
    checks++; if (ifc.out_flags[FLAG_Z] !== 1'b0) begin errors++; $display("FAIL add_zero: got %b want 0", ifc.out_flags[FLAG_Z]); end
    checks++; if (ifc.out_flags !== m[3:0]) begin errors++; $display("FAIL add_flags: got %b want %b", ifc.out_flags, m[3:0]); end
    checks++; if (ifc.out_err !== 1'b0) begin errors++; $display("FAIL add_err: got %b want 0", ifc.out_err); end
    consume();
    checks++; if (ifc.op_count !== 16'(exp_count)) begin errors++; $display("FAIL add_op_count: got %0d want %0d", ifc.op_count, exp_count); end
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL add_idle_valid: got %b want 0", ifc.out_valid); end
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL add_idle_ready: got %b want 1", ifc.in_ready); end
  endtask

  task automatic test_sub();
    issue(8'h05, 8'h05, 4'd1);
    tick();
    checks++; if (ifc.out_result !== 8'h00) begin errors++; $display("FAIL sub_result: got %h want 00", ifc.out_result); end
    checks++; if (ifc.out_flags[FLAG_Z] !== 1'b1) begin errors++; $display("FAIL sub_zero: got %b want 1", ifc.out_flags[FLAG_Z]); end
    checks++; if (ifc.out_flags[FLAG_C] !== 1'b1) begin errors++; $display("FAIL sub_cout: got %b want 1", ifc.out_flags[FLAG_C]); end
    checks++; if (ifc.out_sel !== 4'd1) begin errors++; $display("FAIL sub_sel: got %h want 1", ifc.out_sel); end
    consume();
    checks++; if (ifc.op_count !== 16'(exp_count)) begin errors++; $display("FAIL sub_op_count: got %0d want %0d", ifc.op_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    issue(8'hF0, 8'h3C, 4'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      ifc.in_a = 8'($urandom); ifc.in_b = 8'($urandom); ifc.in_sel = 4'($urandom); ifc.in_valid = 1'b1;
      #1;
      checks++; if ({ifc.out_valid, ifc.in_ready, ifc.out_result} !== {1'b1, 1'b0, 8'h30}) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b r=%b res=%h want v=1 r=0 res=30", i, ifc.out_valid, ifc.in_ready, ifc.out_result); end
      tick();
    end
    ifc.in_a = 8'hF0; ifc.in_b = 8'h0F; ifc.in_sel = 4'd4; ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
    #1;
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", ifc.in_ready); end
    tick();
    exp_count++;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    checks++; if (ifc.op_count !== 16'(exp_count)) begin errors++; $display("FAIL b2b_op_count: got %0d want %0d", ifc.op_count, exp_count); end
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_exec_valid: got %b want 0", ifc.out_valid); end
    tick();
    checks++; if ({ifc.out_valid, ifc.out_result} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL b2b_result: got v=%b res=%h want v=1 res=ff", ifc.out_valid, ifc.out_result); end
    consume();
  endtask

  task automatic test_invalid_sel();
    issue(8'($urandom), 8'($urandom), 4'hF);
    tick();
    checks++; if (ifc.out_err !== 1'b1) begin errors++; $display("FAIL inv_err: got %b want 1", ifc.out_err); end
    checks++; if (ifc.out_result !== 8'h00) begin errors++; $display("FAIL inv_result: got %h want 00", ifc.out_result); end
    checks++; if (ifc.out_flags[FLAG_Z] !== 1'b1) begin errors++; $display("FAIL inv_zero: got %b want 1", ifc.out_flags[FLAG_Z]); end
    checks++; if (ifc.out_sel !== 4'hF) begin errors++; $display("FAIL inv_sel: got %h want f", ifc.out_sel); end
    consume();
    issue(8'h01, 8'h02, 4'd0);
    tick();
    checks++; if ({ifc.out_err, ifc.out_result} !== {1'b0, 8'h03}) begin errors++; $display("FAIL inv_clear: got err=%b res=%h want err=0 res=03", ifc.out_err, ifc.out_result); end
    consume();
  endtask

  task automatic test_reset_mid();
    issue(8'h11, 8'h22, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_count = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ifc.out_valid, ifc.in_ready, ifc.op_count} !== {1'b0, 1'b1, 16'd0}) begin errors++; $display("FAIL rst_exec[%0d]: got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0", i, ifc.out_valid, ifc.in_ready, ifc.op_count); end
      tick();
    end
    issue(8'h33, 8'h44, 4'd5);
    tick();
    consume();
    issue(8'h55, 8'h66, 4'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; exp_count = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ifc.out_valid, ifc.in_ready, ifc.op_count, ifc.out_result} !== {1'b0, 1'b1, 16'd0, 8'h00}) begin errors++; $display("FAIL rst_done[%0d]: got v=%b r=%b cnt=%0d res=%h want 0/1/0/00", i, ifc.out_valid, ifc.in_ready, ifc.op_count, ifc.out_result); end
      tick();
    end
    ifc.in_a = 8'hAA; ifc.in_b = 8'h55; ifc.in_sel = 4'd4; ifc.in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; ifc.in_valid = 1'b0;
    checks++; if ({ifc.alu_a, ifc.alu_b} !== 16'h0000) begin errors++; $display("FAIL rst_over_valid_regs: got %h want 0000", {ifc.alu_a, ifc.alu_b}); end
    tick();
    checks++; if ({ifc.out_valid, ifc.in_ready} !== 2'b01) begin errors++; $display("FAIL rst_over_valid_state: got v=%b r=%b want v=0 r=1", ifc.out_valid, ifc.in_ready); end
  endtask

  task automatic test_random();
    logic [N-1:0] qa[$];
    logic [N-1:0] qb[$];
    logic [3:0]   qs[$];
    int           qk[$];
    logic [N+3:0] m;
    logic         exp_vld;
    logic         exp_rdy;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ifc.in_valid  = (i < 390) ? ($urandom_range(0, 2) != 0) : 1'b0;
      ifc.in_a      = 8'($urandom);
      ifc.in_b      = 8'($urandom);
      ifc.in_sel    = 4'($urandom_range(0, 11));
      ifc.out_ready = (i < 390) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      exp_vld = 1'b0;
      if (qk.size() > 0) exp_vld = ((edges + 1) >= (qk[0] + 2));
      exp_rdy = (qk.size() == 0) || (exp_vld && ifc.out_ready);
      checks++; if (ifc.out_valid !== exp_vld) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, ifc.out_valid, exp_vld); end
      checks++; if (ifc.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ifc.in_ready, exp_rdy); end
      if (exp_vld) begin
        m = alu_model(qa[0], qb[0], qs[0]);
        checks++; if ({ifc.out_result, ifc.out_flags, ifc.out_sel, ifc.out_err} !== {m, qs[0], (qs[0] > 4'd9)}) begin errors++; $display("FAIL rnd_data[%0d]: got res=%h fl=%b sel=%h err=%b want res=%h fl=%b sel=%h err=%b", i, ifc.out_result, ifc.out_flags, ifc.out_sel, ifc.out_err, m[N+3:4], m[3:0], qs[0], (qs[0] > 4'd9)); end
        if (ifc.out_ready) begin
          void'(qa.pop_front()); void'(qb.pop_front()); void'(qs.pop_front()); void'(qk.pop_front());
          exp_count++;
        end
      end
      if (ifc.in_valid && exp_rdy) begin
        qa.push_back(ifc.in_a); qb.push_back(ifc.in_b); qs.push_back(ifc.in_sel); qk.push_back(edges + 1);
      end
      tick();
      checks++; if (ifc.op_count !== 16'(exp_count)) begin errors++; $display("FAIL rnd_op_count[%0d]: got %0d want %0d", i, ifc.op_count, exp_count); end
    end
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d pending want 0", qa.size()); end
    ifc.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_invalid_sel();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
